ternary_mac_driver: RTL and testbench
=====================================

TERNARY_MAC_DRIVER -- requirements
Module: ternary_mac_driver

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: begin one job when sampled high in IDLE.
REQ-004 SHALL have port k_len, input, 8: MAC steps per job, sampled at the accepted start.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1): step-word handshake; transfer = in_valid & in_ready.
REQ-006 SHALL have ports in_w_zero and in_w_sign (inputs, 4 each, bit i = row i) and in_act (input, 8, signed activation).
REQ-007 SHALL have port arr_weights, output, 8: packed ternary codes; row i on bits [7-2i:6-2i]; 0 = 00, +1 = 01, -1 = 10.
REQ-008 SHALL have ports arr_act (output, 8: activation byte) and arr_ena (output, 1: low for exactly one cycle = array readout strobe).
REQ-009 SHALL have port arr_out, input, 8: array result byte stream.
REQ-010 SHALL have ports result_valid (output, 1), result_row (output, 2) and result_byte (output, 8).
REQ-011 SHALL have ports busy (output, 1: high in any state other than IDLE) and done (output, 1: pulse).

Function
REQ-012 SHALL implement states IDLE, FEED, LAST, READ and DRAIN; all array-side outputs are registered and reflect the current state.
REQ-013 IDLE: arr_ena = 0, arr_weights = 0x00, arr_act = 0x00, in_ready = 0; start high -> FEED if k_len != 0, else -> READ.
REQ-014 FEED: arr_ena = 1, in_ready = 1; a word accepted at edge N appears on arr_weights/arr_act during cycle N+1.
REQ-015 FEED: a cycle following an edge with no transfer SHALL show arr_weights = 0x00 and arr_act = 0x00 (bubble, adds nothing).
REQ-016 The step counter SHALL increment per transfer; the k_len-th transfer -> LAST, and in_ready drops in the same edge.
REQ-017 LAST (1 cycle): bus shows the final word with arr_ena = 1, in_ready = 0; -> READ.
REQ-018 READ (1 cycle): arr_ena = 0, arr_weights = 0x00; -> DRAIN with row counter = 0.
REQ-019 DRAIN (4 cycles): arr_ena = 1, arr_weights = 0x00; arr_out is sampled at the end of DRAIN cycle d as row d, for d = 0..3.
REQ-020 Row d SHALL be presented on result_byte/result_row with result_valid high for one cycle, one cycle after its sample edge.
REQ-021 done SHALL pulse together with the row-3 result_valid; the state returns to IDLE on that same edge.
REQ-022 start while busy SHALL be ignored; k_len changes mid-job SHALL have no effect.
REQ-023 Latency for k_len = K with no bubbles: start edge S; row 0 result_valid in cycle S+K+4; done in cycle S+K+7.
REQ-024 k_len = 0: IDLE -> READ directly; result bytes equal whatever arr_out returns, which is 0x00 for a cleared array.

Reset
REQ-025 reset SHALL force IDLE, clear the counters and drive arr_ena = 0, arr_weights = 0x00, arr_act = 0x00, in_ready = 0, result_valid = 0, result_row = 0, result_byte = 0x00, busy = 0 and done = 0.
REQ-026 reset asserted mid-job (any state) SHALL abort the job with no further result_valid or done pulses; reset SHALL win over a simultaneous start.

Configuration
REQ-027 With macro TERNARY_DRIVER_RELU_EN defined: result_byte = 0x00 whenever the sampled arr_out[7] = 1, otherwise arr_out.
REQ-028 With TERNARY_DRIVER_RELU_EN undefined: result_byte = the sampled arr_out unmodified; all timing is identical in both builds.

Verification
REQ-029 Job with k_len = 8, act = 0x7F every step, rows +1/-1/0/(alternating +1,-1), no bubbles -> rows 0x03, 0xFC, 0x00, 0x00, with arr_weights = 0x61/0x62.
REQ-030 Same job built with TERNARY_DRIVER_RELU_EN -> rows 0x03, 0x00, 0x00, 0x00.
REQ-031 Same job with in_valid low on every other cycle -> identical rows; the bubble cycles show arr_weights = 0x00; done arrives 8 cycles later.
REQ-032 k_len = 0 -> exactly one arr_ena-low cycle, then 4 result_valid pulses with rows 0..3 and one done; in_ready never high.
REQ-033 start pulsed during DRAIN -> ignored, no second job; reset asserted in DRAIN cycle 1 -> all outputs zero next cycle, no done.
REQ-034 Timing check, k_len = 3, no bubbles -> arr_ena low exactly in cycle S+5 (S = start edge); result_valid in cycles S+7..S+10.

Source files
------------

// File: rtl/ternary_mac_driver.sv
// ternary_mac_driver: sequences one ternary MAC job into a 4-row array.
// Each accepted step word is put on the array bus for one cycle as packed
// 2-bit ternary weights plus a signed activation byte. After k_len steps the
// driver strobes arr_ena low for one readout cycle. It then samples four
// result rows from arr_out and presents each as a one-cycle result_valid pulse.
// Optional build macro TERNARY_DRIVER_RELU_EN: clamps negative result bytes
// to zero. Timing is identical with and without the macro.
module ternary_mac_driver (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        k_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_w_zero,
  input  logic [3:0]        in_w_sign,
  input  logic signed [7:0] in_act,
  output logic [7:0]        arr_weights,
  output logic [7:0]        arr_act,
  output logic              arr_ena,
  input  logic [7:0]        arr_out,
  output logic              result_valid,
  output logic [1:0]        result_row,
  output logic [7:0]        result_byte,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_LAST  = 3'd2,
    S_READ  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  k_q, k_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic [1:0]  row_q, row_d;
  logic        arr_ena_q, arr_ena_d;
  logic        in_ready_q, in_ready_d;
  logic [7:0]  arr_weights_q, arr_weights_d;
  logic [7:0]  arr_act_q, arr_act_d;
  logic        result_valid_q, result_valid_d;
  logic [1:0]  result_row_q, result_row_d;
  logic [7:0]  result_byte_q, result_byte_d;
  logic        done_q, done_d;
  logic        xfer;

  // Row i occupies bits [7-2i:6-2i]: zero -> 00, +1 -> 01, -1 -> 10.
  function automatic logic [7:0] encode_weights(input logic [3:0] zero,
                                                input logic [3:0] sign);
    logic [7:0] w;
    w = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (!zero[i]) begin
        w[7-2*i -: 2] = sign[i] ? 2'b10 : 2'b01;
      end
    end
    return w;
  endfunction

  // Optional ReLU on the sampled array byte.
  function automatic logic [7:0] shape_result(input logic [7:0] raw);
`ifdef TERNARY_DRIVER_RELU_EN
    return raw[7] ? 8'h00 : raw;
`else
    return raw;
`endif
  endfunction

  assign xfer = in_valid & in_ready_q;

  // Next-state and next-output logic.
  // Bus outputs are computed for the state being entered.
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    cnt_d          = cnt_q;
    cnt_inc        = cnt_q + 8'd1;
    row_d          = row_q;
    arr_ena_d      = 1'b0;
    in_ready_d     = 1'b0;
    arr_weights_d  = 8'h00;
    arr_act_d      = 8'h00;
    result_valid_d = 1'b0;
    result_row_d   = result_row_q;
    result_byte_d  = result_byte_q;
    done_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d   = k_len;
          cnt_d = 8'd0;
          if (k_len != 8'd0) begin
            state_d    = S_FEED;
            arr_ena_d  = 1'b1;
            in_ready_d = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_FEED: begin
        arr_ena_d  = 1'b1;
        in_ready_d = 1'b1;
        if (xfer) begin
          arr_weights_d = encode_weights(in_w_zero, in_w_sign);
          arr_act_d     = $unsigned(in_act);
          cnt_d         = cnt_inc;
          if (cnt_inc == k_q) begin
            state_d    = S_LAST;
            in_ready_d = 1'b0;
          end
        end
      end
      S_LAST: begin
        state_d = S_READ;
      end
      S_READ: begin
        state_d   = S_DRAIN;
        arr_ena_d = 1'b1;
        row_d     = 2'd0;
      end
      S_DRAIN: begin
        arr_ena_d      = 1'b1;
        result_valid_d = 1'b1;
        result_row_d   = row_q;
        result_byte_d  = shape_result(arr_out);
        row_d          = row_q + 2'd1;
        if (row_q == 2'd3) begin
          done_d    = 1'b1;
          state_d   = S_IDLE;
          arr_ena_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      k_q            <= 8'd0;
      cnt_q          <= 8'd0;
      row_q          <= 2'd0;
      arr_ena_q      <= 1'b0;
      in_ready_q     <= 1'b0;
      arr_weights_q  <= 8'h00;
      arr_act_q      <= 8'h00;
      result_valid_q <= 1'b0;
      result_row_q   <= 2'd0;
      result_byte_q  <= 8'h00;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      cnt_q          <= cnt_d;
      row_q          <= row_d;
      arr_ena_q      <= arr_ena_d;
      in_ready_q     <= in_ready_d;
      arr_weights_q  <= arr_weights_d;
      arr_act_q      <= arr_act_d;
      result_valid_q <= result_valid_d;
      result_row_q   <= result_row_d;
      result_byte_q  <= result_byte_d;
      done_q         <= done_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign arr_ena      = arr_ena_q;
  assign arr_weights  = arr_weights_q;
  assign arr_act      = arr_act_q;
  assign result_valid = result_valid_q;
  assign result_row   = result_row_q;
  assign result_byte  = result_byte_q;
  assign done         = done_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_ternary_mac_driver.sv
// Testbench for ternary_mac_driver: directed jobs against a small behavioural
// model of the ternary array (accumulates while enabled, result = acc >>> 8).
module tb_ternary_mac_driver;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [7:0]        k_len;
  logic [3:0]        in_w_zero, in_w_sign;
  logic signed [7:0] in_act;
  logic              in_ready;
  logic [7:0]        arr_weights, arr_act;
  logic              arr_ena;
  logic [7:0]        arr_out;
  logic              result_valid;
  logic [1:0]        result_row;
  logic [7:0]        result_byte;
  logic              busy, done;

`ifdef TERNARY_DRIVER_RELU_EN
  localparam logic [7:0] EXP_J1_R1 = 8'h00;
  localparam logic [7:0] EXP_J4_R1 = 8'h00;
`else
  localparam logic [7:0] EXP_J1_R1 = 8'hFC;
  localparam logic [7:0] EXP_J4_R1 = 8'hFE;
`endif

  ternary_mac_driver dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_w_zero(in_w_zero), .in_w_sign(in_w_sign), .in_act(in_act),
    .arr_weights(arr_weights), .arr_act(arr_act), .arr_ena(arr_ena),
    .arr_out(arr_out),
    .result_valid(result_valid), .result_row(result_row),
    .result_byte(result_byte), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Array model
  int         acc [4];
  logic [7:0] snap [4];
  logic [1:0] rd_idx;
  logic       draining;

  function automatic int wval(input logic [1:0] c);
    return (c == 2'b01) ? 1 : (c == 2'b10) ? -1 : 0;
  endfunction

  function automatic logic [7:0] sh8(input int a);
    int t;
    t = a >>> 8;
    return t[7:0];
  endfunction

  assign arr_out = snap[rd_idx];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        acc[i]  <= 0;
        snap[i] <= 8'h00;
      end
      rd_idx   <= 2'd0;
      draining <= 1'b0;
    end else if (busy && !arr_ena) begin
      for (int i = 0; i < 4; i++) begin
        snap[i] <= sh8(acc[i]);
        acc[i]  <= 0;
      end
      rd_idx   <= 2'd0;
      draining <= 1'b1;
    end else if (arr_ena) begin
      for (int i = 0; i < 4; i++)
        acc[i] <= acc[i] + wval(arr_weights[7-2*i -: 2]) * int'($signed(arr_act));
      if (draining) begin
        rd_idx <= rd_idx + 2'd1;
        if (rd_idx == 2'd3) draining <= 1'b0;
      end
    end
  end

  // Output monitor, sampled on the falling edge
  logic [7:0] rbyte [64];
  int         rrow [64];
  int         rcyc [64];
  int nres = 0, ndone = 0, dcyc = 0, nlow = 0, lowcyc = 0;
  int rdy_cnt = 0, w61 = 0, w62 = 0, bub0 = 0;

  always @(negedge clk) begin
    if (result_valid && nres < 64) begin
      rbyte[nres] = result_byte;
      rrow[nres]  = result_row;
      rcyc[nres]  = cyc + 1;
      nres++;
    end
    if (done) begin
      ndone++;
      dcyc = cyc + 1;
    end
    if (busy && !arr_ena) begin
      nlow++;
      lowcyc = cyc + 1;
    end
    if (in_ready) rdy_cnt++;
    if (arr_ena && arr_weights == 8'h61) w61++;
    if (arr_ena && arr_weights == 8'h62) w62++;
    if (in_ready && arr_ena && arr_weights == 8'h00 && arr_act == 8'h00) bub0++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a job and feed k step words; rows: +1, -1, 0, alternating +1/-1.
  task automatic run_job(input int k, input bit bub, output int s);
    int n;
    int guard;
    bit ph;
    bit rdy;
    start = 1'b1;
    k_len = k[7:0];
    step();
    s     = cyc;
    start = 1'b0;
    k_len = 8'h01;
    n = 0; ph = 1'b0; guard = 0;
    while (n < k && guard < 100) begin
      in_valid  = bub ? ph : 1'b1;
      in_w_zero = 4'b0100;
      in_w_sign = {n[0], 1'b0, 1'b1, 1'b0};
      in_act    = 8'sh7F;
      rdy       = in_ready;
      step();
      if (rdy && in_valid) n++;
      ph = ~ph;
      guard++;
    end
    in_valid = 1'b0;
    if (n < k) chk("feed_timeout", n, k);
  endtask

  task automatic wait_done(input int d0, input int lim);
    int g;
    g = 0;
    while (ndone == d0 && g < lim) begin
      step();
      g++;
    end
    if (ndone == d0) chk("done_timeout", 0, 1);
    step();
  endtask

  int s, b, d0, w61_0, w62_0, bub_0, low_0, rdy_0;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; k_len = 8'd0;
    in_w_zero = 4'd0; in_w_sign = 4'd0; in_act = 8'sd0;
    repeat (3) step();
    chk("rst_outs", {arr_ena, arr_weights, arr_act, in_ready, result_valid,
                     result_row, result_byte, busy, done}, 0);
    start = 1'b1; k_len = 8'd8;
    step();
    chk("rst_beats_start", busy, 0);
    start = 1'b0; reset = 1'b0;
    step();

    // Job 1: k_len = 8, no bubbles
    b = nres; d0 = ndone; w61_0 = w61; w62_0 = w62;
    run_job(8, 1'b0, s);
    wait_done(d0, 60);
    chk("j1_nres", nres - b, 4);
    chk("j1_row0", rbyte[b], 8'h03);
    chk("j1_row1", rbyte[b+1], EXP_J1_R1);
    chk("j1_row2", rbyte[b+2], 8'h00);
    chk("j1_row3", rbyte[b+3], 8'h00);
    chk("j1_rowidx3", rrow[b+3], 3);
    chk("j1_row0_cyc", rcyc[b] - s, 12);
    chk("j1_done_cyc", dcyc - s, 15);
    chk("j1_w61", w61 - w61_0, 4);
    chk("j1_w62", w62 - w62_0, 4);
    chk("j1_idle", busy, 0);

    // Job 2: same job, in_valid low every other cycle
    b = nres; d0 = ndone; bub_0 = bub0;
    run_job(8, 1'b1, s);
    wait_done(d0, 80);
    chk("j2_nres", nres - b, 4);
    chk("j2_row0", rbyte[b], 8'h03);
    chk("j2_row1", rbyte[b+1], EXP_J1_R1);
    chk("j2_row3", rbyte[b+3], 8'h00);
    chk("j2_done_cyc", dcyc - s, 23);
    chk("j2_bubbles", bub0 - bub_0, 9);

    // Job 3: k_len = 0
    b = nres; d0 = ndone; low_0 = nlow; rdy_0 = rdy_cnt;
    run_job(0, 1'b0, s);
    wait_done(d0, 20);
    chk("j3_low_cnt", nlow - low_0, 1);
    chk("j3_low_cyc", lowcyc - s, 1);
    chk("j3_ready", rdy_cnt - rdy_0, 0);
    chk("j3_nres", nres - b, 4);
    chk("j3_ndone", ndone - d0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("j3_rowidx", rrow[b+i], i);
      chk("j3_byte", rbyte[b+i], 8'h00);
    end

    // Job 4: k_len = 3 timing, start pulsed in DRAIN cycle 0
    b = nres; d0 = ndone; low_0 = nlow;
    run_job(3, 1'b0, s);
    while (cyc < s + 5) step();
    start = 1'b1; k_len = 8'd2;
    step();
    start = 1'b0;
    wait_done(d0, 20);
    repeat (8) step();
    chk("j4_low_cnt", nlow - low_0, 1);
    chk("j4_low_cyc", lowcyc - s, 5);
    chk("j4_row0_cyc", rcyc[b] - s, 7);
    chk("j4_row3_cyc", rcyc[b+3] - s, 10);
    chk("j4_done_cyc", dcyc - s, 10);
    chk("j4_row0", rbyte[b], 8'h01);
    chk("j4_row1", rbyte[b+1], EXP_J4_R1);
    chk("j4_nres", nres - b, 4);
    chk("j4_ndone", ndone - d0, 1);
    chk("j4_no_restart", busy, 0);

    // Job 5: reset asserted in DRAIN cycle 1
    b = nres; d0 = ndone;
    run_job(3, 1'b0, s);
    while (cyc < s + 6) step();
    reset = 1'b1;
    step();
    chk("j5_rst_outs", {arr_ena, arr_weights, arr_act, in_ready, result_valid,
                        result_row, result_byte, busy, done}, 0);
    reset = 1'b0;
    repeat (10) step();
    chk("j5_nres", nres - b, 1);
    chk("j5_ndone", ndone - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
